// File: rtl/ysyx_core_ctrl.sv
// rtl/ysyx_core_ctrl.sv - multi-cycle fetch/execute/memory/writeback sequencer for the RV32 NPC core
module ysyx_core_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_data,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_do_jump,
   input  logic        dec_is_ebreak,
   input  logic        dec_rf_wr_en,
   input  logic [31:0] jump_target,
   output logic        lsu_req_valid,
   output logic        lsu_req_we,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   output logic        rf_wr_strobe,
   output logic        halted,
   output logic        error,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXEC,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_HALT,
      S_ERR
   } state_e;

   // Counter value seen during the TIMEOUT-th cycle of a wait state
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic [7:0]  tmo_q, tmo_d;

   logic        tmo_hit;
   logic        jump_misaligned;

   assign tmo_hit         = (tmo_q == TMO_LAST);
   assign jump_misaligned = dec_do_jump && (jump_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= 32'd0;
         instret_q <= 32'd0;
         tmo_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      instret_d     = instret_q;
      tmo_d         = 8'd0;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_we    = 1'b0;
      rf_wr_strobe  = 1'b0;

      case (state_q)
         S_FETCH_REQ: begin
            ifu_req_valid = 1'b1;
            if (ifu_req_ready) begin
               state_d = S_FETCH_WAIT;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_FETCH_WAIT: begin
            if (ifu_rsp_valid) begin
               inst_d  = ifu_rsp_data;
               state_d = S_EXEC;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_EXEC: begin
            if (dec_is_ebreak) begin
               state_d = S_HALT;
            end else if (dec_is_load || dec_is_store) begin
               state_d = S_MEM_REQ;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM_REQ: begin
            lsu_req_valid = 1'b1;
            lsu_req_we    = dec_is_store;
            if (lsu_req_ready) begin
               state_d = S_MEM_WAIT;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_MEM_WAIT: begin
            if (lsu_rsp_valid) begin
               state_d = S_WB;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_WB: begin
            // A misaligned jump kills the instruction: no retire, PC kept for debug
            if (jump_misaligned) begin
               state_d = S_ERR;
            end else begin
               rf_wr_strobe = dec_rf_wr_en;
               pc_d         = dec_do_jump ? jump_target : pc_q + 32'd4;
               instret_d    = instret_q + 32'd1;
               state_d      = S_FETCH_REQ;
            end
         end

         S_HALT: state_d = S_HALT;

         S_ERR: state_d = S_ERR;

         default: state_d = S_ERR;
      endcase
   end

   assign ifu_req_addr = pc_q;
   assign pc           = pc_q;
   assign inst         = inst_q;
   assign instret      = instret_q;
   assign halted       = (state_q == S_HALT);
   assign error        = (state_q == S_ERR);

endmodule

// File: tb/tb_ysyx_core_ctrl.sv
// tb/tb_ysyx_core_ctrl.sv - directed self-checking bench for ysyx_core_ctrl
module tb_ysyx_core_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] JAL    = 32'h1000_00ef;
   localparam logic [31:0] SW     = 32'h0020_a023;
   localparam logic [31:0] LW     = 32'h0000_a103;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk, rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_req_addr, ifu_rsp_data, inst, pc, jump_target, instret;
   logic        dec_is_load, dec_is_store, dec_do_jump, dec_is_ebreak, dec_rf_wr_en;
   logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
   logic        rf_wr_strobe, halted, error;

   int n_assert = 0;
   int n_fail   = 0;

   ysyx_core_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_data  (ifu_rsp_data),
      .inst          (inst),
      .pc            (pc),
      .dec_is_load   (dec_is_load),
      .dec_is_store  (dec_is_store),
      .dec_do_jump   (dec_do_jump),
      .dec_is_ebreak (dec_is_ebreak),
      .dec_rf_wr_en  (dec_rf_wr_en),
      .jump_target   (jump_target),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_we    (lsu_req_we),
      .lsu_req_ready (lsu_req_ready),
      .lsu_rsp_valid (lsu_rsp_valid),
      .rf_wr_strobe  (rf_wr_strobe),
      .halted        (halted),
      .error         (error),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'd0;
      dec_is_load = 1'b0; dec_is_store = 1'b0; dec_do_jump = 1'b0;
      dec_is_ebreak = 1'b0; dec_rf_wr_en = 1'b0; jump_target = 32'd0;
      lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
      cyc(); cyc();
      chk("rst_pc", pc, RST_PC);
      chk("rst_inst", inst, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_lsu_valid", lsu_req_valid, 1'b0);
      chk("rst_strobe", rf_wr_strobe, 1'b0);
      chk("rst_ifu_valid", ifu_req_valid, 1'b1);
      rst = 1'b0;

      // addi, zero-wait memory
      ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_data = ADDI;
      dec_rf_wr_en = 1'b1; lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
      chk("addi_c1_ifu_valid", ifu_req_valid, 1'b1);
      chk("addi_c1_addr", ifu_req_addr, RST_PC);
      cyc();
      chk("addi_c2_ifu_valid", ifu_req_valid, 1'b0);
      cyc();
      chk("addi_c3_inst", inst, ADDI);
      chk("addi_c3_strobe", rf_wr_strobe, 1'b0);
      cyc();
      chk("addi_c4_strobe", rf_wr_strobe, 1'b1);
      chk("addi_c4_pc", pc, RST_PC);
      cyc();
      chk("addi_next_strobe", rf_wr_strobe, 1'b0);
      chk("addi_pc", pc, 32'h8000_0004);
      chk("addi_instret", instret, 32'd1);
      chk("addi_next_addr", ifu_req_addr, 32'h8000_0004);

      // jal to aligned target
      ifu_rsp_data = JAL; dec_do_jump = 1'b1; jump_target = 32'h8000_0100;
      cyc(); cyc(); cyc();
      chk("jal_strobe", rf_wr_strobe, 1'b1);
      cyc();
      dec_do_jump = 1'b0;
      chk("jal_pc", pc, 32'h8000_0100);
      chk("jal_addr", ifu_req_addr, 32'h8000_0100);
      chk("jal_instret", instret, 32'd2);

      // store with lsu_req_ready delayed 3 cycles
      ifu_rsp_data = SW; dec_is_store = 1'b1; dec_rf_wr_en = 1'b0;
      lsu_req_ready = 1'b0;
      cyc(); cyc();
      chk("sw_exec_lsu_valid", lsu_req_valid, 1'b0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) lsu_req_ready = 1'b1;
         chk($sformatf("sw_req%0d_valid", i), lsu_req_valid, 1'b1);
         chk($sformatf("sw_req%0d_we", i), lsu_req_we, 1'b1);
         cyc();
      end
      chk("sw_wait_lsu_valid", lsu_req_valid, 1'b0);
      cyc();
      chk("sw_wb_strobe", rf_wr_strobe, 1'b0);
      cyc();
      chk("sw_instret", instret, 32'd3);
      chk("sw_pc", pc, 32'h8000_0104);
      chk("sw_ifu_valid", ifu_req_valid, 1'b1);
      dec_is_store = 1'b0; dec_rf_wr_en = 1'b1;

      // misaligned jump target
      ifu_rsp_data = JAL; dec_do_jump = 1'b1; jump_target = 32'h8000_0102;
      cyc(); cyc(); cyc();
      chk("mis_wb_strobe", rf_wr_strobe, 1'b0);
      cyc();
      chk("mis_error", error, 1'b1);
      chk("mis_pc", pc, 32'h8000_0104);
      chk("mis_instret", instret, 32'd3);
      chk("mis_ifu_valid", ifu_req_valid, 1'b0);
      cyc(); cyc();
      chk("mis_sticky_error", error, 1'b1);
      chk("mis_sticky_ifu", ifu_req_valid, 1'b0);
      dec_do_jump = 1'b0;

      // ebreak beats a simultaneous load decode
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("rst2_error", error, 1'b0);
      ifu_rsp_data = EBREAK; dec_is_ebreak = 1'b1; dec_is_load = 1'b1;
      cyc(); cyc();
      chk("ebreak_exec_halted", halted, 1'b0);
      cyc();
      chk("ebreak_halted", halted, 1'b1);
      chk("ebreak_instret", instret, 32'd0);
      chk("ebreak_lsu_valid", lsu_req_valid, 1'b0);
      chk("ebreak_ifu_valid", ifu_req_valid, 1'b0);
      chk("ebreak_strobe", rf_wr_strobe, 1'b0);
      repeat (3) cyc();
      chk("ebreak_sticky", halted, 1'b1);
      chk("ebreak_no_req", ifu_req_valid, 1'b0);
      dec_is_ebreak = 1'b0; dec_is_load = 1'b0;

      // fetch response never arrives
      rst = 1'b1; cyc(); rst = 1'b0;
      ifu_rsp_valid = 1'b0;
      cyc();
      repeat (254) cyc();
      chk("tmo_c255_error", error, 1'b0);
      cyc();
      chk("tmo_error", error, 1'b1);
      chk("tmo_ifu_valid", ifu_req_valid, 1'b0);
      cyc();
      chk("tmo_sticky", ifu_req_valid, 1'b0);

      // response on the last allowed cycle wins
      rst = 1'b1; cyc(); rst = 1'b0;
      cyc();
      repeat (254) cyc();
      ifu_rsp_valid = 1'b1; ifu_rsp_data = ADDI;
      cyc();
      chk("tmo_edge_error", error, 1'b0);
      chk("tmo_edge_inst", inst, ADDI);
      cyc(); cyc();
      chk("tmo_edge_instret", instret, 32'd1);
      chk("tmo_edge_pc", pc, 32'h8000_0004);

      // reset during MEM_WAIT, late response after release
      dec_is_load = 1'b1; lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b0;
      ifu_rsp_data = LW;
      cyc(); cyc(); cyc();
      chk("lw_req_valid", lsu_req_valid, 1'b1);
      chk("lw_req_we", lsu_req_we, 1'b0);
      cyc();
      chk("lw_wait_valid", lsu_req_valid, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_instret", instret, 32'd0);
      chk("async_rst_pc", pc, RST_PC);
      cyc();
      rst = 1'b0;
      ifu_req_ready = 1'b0; lsu_rsp_valid = 1'b1;
      cyc();
      chk("late_rsp_ifu_valid", ifu_req_valid, 1'b1);
      chk("late_rsp_addr", ifu_req_addr, RST_PC);
      chk("late_rsp_strobe", rf_wr_strobe, 1'b0);
      cyc();
      chk("late_rsp_instret", instret, 32'd0);
      chk("late_rsp_lsu_valid", lsu_req_valid, 1'b0);
      chk("late_rsp_ifu_valid2", ifu_req_valid, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
